// File: rtl/recv_pkg.sv
// Shared definitions for the byte-framed receive path (also usable by the TX framer).
package recv_pkg;

  typedef enum logic [2:0] {
    ST_HUNT0   = 3'd0,
    ST_HUNT1   = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4
  } recv_state_t;

  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [7:0] HDR0_DEF = 8'h55;
  localparam logic [7:0] HDR1_DEF = 8'hAA;

  // Checksum is a plain mod-256 sum over LEN and payload bytes.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/recv_frame_ctrl_if.sv
// FIFO read handshake plus payload stream, grouped as one bundle.
interface recv_frame_ctrl_if;
  logic       fifo_rd_vld;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_en;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_sop;
  logic       m_eop;
  logic       m_ready;

  modport master (
    input  fifo_rd_vld, fifo_rd_data, m_ready,
    output fifo_rd_en, m_data, m_valid, m_sop, m_eop
  );

  modport slave (
    output fifo_rd_vld, fifo_rd_data, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_sop, m_eop
  );
endinterface

// File: rtl/recv_skid_reg.sv
// Payload output register: byte plus sop/eop, held while the sink stalls.
module recv_skid_reg (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_sop,
  input  logic       i_eop,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_sop,
  output logic       o_eop
);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      o_data  <= 8'h00;
      o_valid <= 1'b0;
      o_sop   <= 1'b0;
      o_eop   <= 1'b0;
    end else if (i_load) begin
      o_data  <= i_data;
      o_valid <= 1'b1;
      o_sop   <= i_sop;
      o_eop   <= i_eop;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/recv_frame_ctrl.sv
// Receive frame sequencer: pops FIFO bytes, hunts [HDR0][HDR1][LEN][payload][CSUM],
// forwards payload and pulses frame status.
//   state      | meaning
//   ST_HUNT0   | waiting for HDR0
//   ST_HUNT1   | HDR0 seen, waiting for HDR1
//   ST_LEN     | next byte is LEN
//   ST_PAYLOAD | forwarding payload bytes
//   ST_CSUM    | next byte is checksum
module recv_frame_ctrl
  import recv_pkg::*;
#(
  parameter int unsigned MAX_LEN = 255,
  parameter int unsigned TIMEOUT = 1024,
  parameter logic [7:0]  HDR0    = HDR0_DEF,
  parameter logic [7:0]  HDR1    = HDR1_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  recv_frame_ctrl_if.master bus,
  output logic              frame_done,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic [15:0]       frame_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

  recv_state_t      r_state, w_state_nxt;
  logic [7:0]       r_sum, w_sum_nxt;
  logic [7:0]       r_len, w_len_nxt;
  logic             r_first, w_first_nxt;
  logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
  logic             r_frame_done, r_frame_err;
  logic [1:0]       r_err_code, w_err_code;
  logic [15:0]      r_frame_cnt;
  logic             w_done, w_err;
  logic             w_accept, w_pop;
  logic             w_load, w_sop, w_eop;
  logic [7:0]       w_byte;

  // Payload only pops when the output register is free or draining this cycle.
  assign w_accept       = (r_state == ST_PAYLOAD) ? (~bus.m_valid | bus.m_ready) : 1'b1;
  assign w_pop          = bus.fifo_rd_vld & w_accept;
  assign w_byte         = bus.fifo_rd_data;
  assign bus.fifo_rd_en = w_pop;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_HUNT0;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sum_nxt   = r_sum;
    w_len_nxt   = r_len;
    w_first_nxt = r_first;
    w_tmo_nxt   = r_tmo;
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_err_code  = r_err_code;
    w_load      = 1'b0;
    w_sop       = 1'b0;
    w_eop       = 1'b0;
    if (w_pop) begin
      w_tmo_nxt = '0;
      unique case (r_state)
        ST_HUNT0: if (w_byte == HDR0) w_state_nxt = ST_HUNT1;
        ST_HUNT1: begin
          if (w_byte == HDR1)      w_state_nxt = ST_LEN;
          else if (w_byte == HDR0) w_state_nxt = ST_HUNT1;
          else                     w_state_nxt = ST_HUNT0;
        end
        ST_LEN: begin
          w_sum_nxt   = w_byte;
          w_len_nxt   = w_byte;
          w_first_nxt = 1'b1;
          if (w_byte == 8'd0) begin
            w_state_nxt = ST_CSUM;
          end else if ({1'b0, w_byte} > MAX_LEN_W) begin
            w_err       = 1'b1;
            w_err_code  = ERR_LEN;
            w_state_nxt = ST_HUNT0;
          end else begin
            w_state_nxt = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          w_sum_nxt   = csum_add(r_sum, w_byte);
          w_load      = 1'b1;
          w_sop       = r_first;
          w_eop       = (r_len == 8'd1);
          w_first_nxt = 1'b0;
          w_len_nxt   = r_len - 8'd1;
          if (r_len == 8'd1) w_state_nxt = ST_CSUM;
        end
        ST_CSUM: begin
          if (w_byte == r_sum) begin
            w_done = 1'b1;
          end else begin
            w_err      = 1'b1;
            w_err_code = ERR_CSUM;
          end
          w_state_nxt = ST_HUNT0;
        end
        default: w_state_nxt = ST_HUNT0;
      endcase
    end else if (r_state != ST_HUNT0) begin
      // Any cycle without a pop mid-frame counts, including sink back-pressure.
      if (r_tmo == TMO_LAST) begin
        w_err       = 1'b1;
        w_err_code  = ERR_TMO;
        w_tmo_nxt   = '0;
        w_state_nxt = ST_HUNT0;
      end else begin
        w_tmo_nxt = r_tmo + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sum        <= 8'h00;
      r_len        <= 8'h00;
      r_first      <= 1'b0;
      r_tmo        <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_code   <= 2'd0;
      r_frame_cnt  <= 16'd0;
    end else begin
      r_sum        <= w_sum_nxt;
      r_len        <= w_len_nxt;
      r_first      <= w_first_nxt;
      r_tmo        <= w_tmo_nxt;
      r_frame_done <= w_done;
      r_frame_err  <= w_err;
      r_err_code   <= w_err_code;
      r_frame_cnt  <= r_frame_cnt + {15'd0, w_done};
    end
  end

  recv_skid_reg u_out (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_load    (w_load),
    .i_data    (w_byte),
    .i_sop     (w_sop),
    .i_eop     (w_eop),
    .i_ready   (bus.m_ready),
    .o_data    (bus.m_data),
    .o_valid   (bus.m_valid),
    .o_sop     (bus.m_sop),
    .o_eop     (bus.m_eop)
  );

  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign err_code   = r_err_code;
  assign frame_cnt  = r_frame_cnt;

endmodule
